// File: rtl/apb_wait_cycle_ctrl.sv
// Programmable APB wait-state controller: latches a per-direction wait count at setup and holds PREADY low for that many cycles.
// Optional slave-error path enabled by defining APB_WAIT_SLVERR_EN.
module apb_wait_cycle_ctrl #(
    parameter int CNT_W    = 4,
    parameter int RST_WAIT = 0
) (
    input  logic             PCLK,
    input  logic             PRESET,
    input  logic             PSEL,
    input  logic             PENABLE,
    input  logic             PWRITE,
    input  logic             access,
    input  logic             addr_err,
    input  logic [CNT_W-1:0] rd_wait,
    input  logic [CNT_W-1:0] wr_wait,
    output logic             PREADY,
    output logic             PSLVERR,
    output logic [CNT_W-1:0] wait_counter,
    output logic             xfer_done,
    output logic             busy
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] RST_WAIT_C = RST_WAIT[CNT_W-1:0];

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] tgt_wait_q, tgt_wait_d;
    logic [CNT_W-1:0] sel_wait_s;
    logic             setup_s;
    logic             ready_s;
    logic             complete_s;

    assign setup_s    = PSEL & ~PENABLE & access;
    // Ready depends only on flops, so there is no path from the APB inputs to PREADY.
    assign ready_s    = (state_q == ST_ACCESS) && (cnt_q == tgt_wait_q);
    assign complete_s = PSEL & PENABLE & ready_s;

`ifdef APB_WAIT_SLVERR_EN
    logic err_q, err_d;

    // An illegal address completes with zero wait so the error returns fast.
    always_comb begin
        if (addr_err) begin
            sel_wait_s = CNT_ZERO;
        end else begin
            sel_wait_s = PWRITE ? wr_wait : rd_wait;
        end
    end
`else
    logic unused_addr_err_s;
    assign unused_addr_err_s = addr_err;

    // Wait count chosen by transfer direction only.
    always_comb begin
        sel_wait_s = PWRITE ? wr_wait : rd_wait;
    end
`endif

    // Next-state, counter and latch logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tgt_wait_d = tgt_wait_q;
`ifdef APB_WAIT_SLVERR_EN
        err_d      = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                cnt_d = CNT_ZERO;
                if (setup_s) begin
                    state_d    = ST_ACCESS;
                    tgt_wait_d = sel_wait_s;
`ifdef APB_WAIT_SLVERR_EN
                    err_d      = addr_err;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (!PSEL || complete_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
`ifdef APB_WAIT_SLVERR_EN
                    err_d   = 1'b0;
`endif
                end else if (PENABLE && !ready_s) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // State register with synchronous reset taking priority.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q    <= ST_IDLE;
            cnt_q      <= CNT_ZERO;
            tgt_wait_q <= RST_WAIT_C;
`ifdef APB_WAIT_SLVERR_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tgt_wait_q <= tgt_wait_d;
`ifdef APB_WAIT_SLVERR_EN
            err_q      <= err_d;
`endif
        end
    end

    assign PREADY       = ready_s;
    assign busy         = (state_q == ST_ACCESS);
    assign wait_counter = cnt_q;
    assign xfer_done    = complete_s;
`ifdef APB_WAIT_SLVERR_EN
    assign PSLVERR      = err_q & ready_s;
`else
    assign PSLVERR      = 1'b0;
`endif

endmodule
